// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Purpose  : Shared APB requester types: FSM state encoding and command/response records.
// Revision : 1.0
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_if
// Purpose  : APB3 bus bundle with requester (master) and completer (slave) views.
// Revision : 1.0
// ============================================================================
interface apb_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master
// Purpose  : Turns single valid/ready commands into APB transfers with a pready timeout.
// Revision : 1.0
// ============================================================================
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic              pclk,
    input  wire logic              presetn,
    input  wire logic              cmd_valid,
    output logic                   cmd_ready,
    input  wire logic              cmd_write,
    input  wire logic [ADDR_W-1:0] cmd_addr,
    input  wire logic [DATA_W-1:0] cmd_wdata,
    output logic                   rsp_valid,
    input  wire logic              rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    apb_if.master                  apb
);

    localparam int             CNT_W   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    apb_mst_state_t   state;
    apb_mst_state_t   state_next;
    logic [CNT_W-1:0] cnt;
    logic             done_ok;
    logic             done_to;
    logic             accept;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && (state == IDLE);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (apb.pready) begin
                    state_next = RESP;
                    done_ok    = 1'b1;
                end else if (TO_EN && (cnt == TO_LAST)) begin
                    state_next = RESP;
                    done_to    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus strobes follow the next state so they are registered yet aligned with it.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.paddr   <= '0;
            apb.pwrite  <= 1'b0;
            apb.pwdata  <= '0;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            apb.psel    <= (state_next == SETUP) || (state_next == ACCESS);
            apb.penable <= (state_next == ACCESS);

            if (accept) begin
                apb.paddr  <= cmd_addr;
                apb.pwrite <= cmd_write;
                apb.pwdata <= cmd_write ? cmd_wdata : '0;
            end

            if (state == SETUP) begin
                cnt <= '0;
            end else if ((state == ACCESS) && !apb.pready && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end

            if (done_ok) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= (!apb.pwrite && !apb.pslverr) ? apb.prdata : '0;
                rsp_err     <= apb.pslverr;
                rsp_timeout <= 1'b0;
            end else if (done_to) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cmd_master
// Purpose  : Directed self-checking bench with a 16x8 APB slave model.
// Revision : 1.0
// ============================================================================
module tb_apb_cmd_master;
    import apb_pkg::*;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int checks   = 0;
    int failures = 0;

    apb_if #(.ADDR_W(32), .DATA_W(8)) bus ();

    apb_cmd_master #(.ADDR_W(32), .DATA_W(8), .TIMEOUT_CYCLES(4)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb         (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Slave model: 16 bytes, addresses >= 16 answer with pslverr.
    logic [7:0] mem [16];
    int         wait_n = 0;
    logic       dead   = 1'b0;
    int         acc_cnt = 0;
    int         psel_n = 0;
    int         pen_n  = 0;

    assign bus.pready  = !dead && (acc_cnt >= wait_n);
    assign bus.pslverr = (bus.paddr >= 32'd16);
    assign bus.prdata  = (bus.paddr < 32'd16) ? mem[bus.paddr[3:0]] : 8'hEE;

    always @(posedge pclk) begin
        if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
        else                                        acc_cnt <= 0;
        if (bus.psel && bus.penable && bus.pready && bus.pwrite && (bus.paddr < 32'd16))
            mem[bus.paddr[3:0]] <= bus.pwdata;
    end

    always @(negedge pclk) begin
        if (bus.psel)    psel_n <= psel_n + 1;
        if (bus.penable) pen_n  <= pen_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command; lat = edges from acceptance to rsp_valid, bad = APB field changes while selected.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [7:0] d,
                        output int lat, output int ps, output int pe, output int bad);
        int n;
        int p0, e0;
        bad = 0;
        @(negedge pclk);
        p0 = psel_n; e0 = pen_n;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge pclk); n++; end
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            if (bus.psel && ((bus.paddr !== a) || (bus.pwrite !== w) ||
                             (bus.pwdata !== (w ? d : 8'h00)))) bad++;
            @(posedge pclk); #1;
            lat++;
        end
        @(negedge pclk);
        ps = psel_n - p0; pe = pen_n - e0;
    endtask

    task automatic consume();
        @(negedge pclk);
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat, ps, pe, bad, n;
        logic [7:0] r0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_psel",      32'(bus.psel), 32'd0);
        chk("rst_penable",   32'(bus.penable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        presetn = 1'b1;

        // Zero-wait write then read-back.
        xfer(1'b1, 32'd5, 8'hA5, lat, ps, pe, bad);
        chk("wr_latency",  32'(lat), 32'd2);
        chk("wr_psel_cyc", 32'(ps), 32'd2);
        chk("wr_pen_cyc",  32'(pe), 32'd1);
        chk("wr_err",      32'(rsp_err), 32'd0);
        chk("wr_rdata",    32'(rsp_rdata), 32'd0);
        chk("wr_fields",   32'(bad), 32'd0);
        consume();
        chk("wr_rsp_clr",  32'(rsp_valid), 32'd0);
        chk("wr_idle_rdy", 32'(cmd_ready), 32'd1);

        xfer(1'b0, 32'd5, 8'h00, lat, ps, pe, bad);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_rdata",   32'(rsp_rdata), 32'hA5);
        chk("rd_err",     32'(rsp_err), 32'd0);
        chk("rd_pen_cyc", 32'(pe), 32'd1);
        consume();

        // Out-of-range address: slave error, data masked.
        xfer(1'b0, 32'd20, 8'h00, lat, ps, pe, bad);
        chk("err_err",     32'(rsp_err), 32'd1);
        chk("err_timeout", 32'(rsp_timeout), 32'd0);
        chk("err_rdata",   32'(rsp_rdata), 32'd0);
        consume();

        // Three wait states: ACCESS is four cycles with stable fields.
        wait_n = 3;
        xfer(1'b1, 32'd3, 8'h3C, lat, ps, pe, bad);
        chk("ws_latency", 32'(lat), 32'd5);
        chk("ws_pen_cyc", 32'(pe), 32'd4);
        chk("ws_stable",  32'(bad), 32'd0);
        chk("ws_err",     32'(rsp_err), 32'd0);
        consume();
        xfer(1'b0, 32'd3, 8'h00, lat, ps, pe, bad);
        chk("ws_rd_rdata", 32'(rsp_rdata), 32'h3C);
        consume();
        wait_n = 0;

        // Dead slave: timeout after four ACCESS cycles.
        dead = 1'b1;
        xfer(1'b0, 32'd7, 8'h00, lat, ps, pe, bad);
        chk("to_latency", 32'(lat), 32'd5);
        chk("to_pen_cyc", 32'(pe), 32'd4);
        chk("to_err",     32'(rsp_err), 32'd1);
        chk("to_timeout", 32'(rsp_timeout), 32'd1);
        chk("to_rdata",   32'(rsp_rdata), 32'd0);
        chk("to_psel",    32'(bus.psel), 32'd0);
        consume();
        dead = 1'b0;

        // Response backpressure with a second command already waiting.
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd9; cmd_wdata = 8'h11;
        @(posedge pclk); #1;
        cmd_write = 1'b0; cmd_wdata = 8'h00;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge pclk); #1; n++; end
        r0 = rsp_rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_stable", {23'd0, rsp_err, rsp_rdata}, {23'd0, 1'b0, r0});
            chk("bp_psel",      32'(bus.psel), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
        chk("bp_rsp_clr",   32'(rsp_valid), 32'd0);
        chk("bp_ready_now", 32'(cmd_ready), 32'd1);
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        chk("bp2_psel",    32'(bus.psel), 32'd1);
        chk("bp2_penable", 32'(bus.penable), 32'd0);
        chk("bp2_pwrite",  32'(bus.pwrite), 32'd0);
        chk("bp2_paddr",   bus.paddr, 32'd9);
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge pclk); #1; n++; end
        chk("bp2_rdata", 32'(rsp_rdata), 32'h11);
        consume();

        // Asynchronous reset in the middle of ACCESS.
        dead = 1'b1;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd2;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        chk("mr_in_access", 32'(bus.penable), 32'd1);
        #2 presetn = 1'b0;
        #1;
        chk("mr_psel",      32'(bus.psel), 32'd0);
        chk("mr_penable",   32'(bus.penable), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        dead = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("mr_no_rsp",    32'(rsp_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
